led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TICK_DIV, default 12000: clk cycles per tick (1 kHz at 12 MHz); legal range 2..65535.
REQ-003 Parameter PULSE_TICKS, default 200: one-shot on-time in ticks; legal range 1..255.
REQ-004 Port list, clock and reset first:
  clk        in   1   system clock (12 MHz+)
  rst_n      in   1   async active-low reset
  clr        in   1   synchronous clear of all LED entries
  wr_valid   in   1   write request
  wr_ready   out  1   write accept; comb = rst_n & ~clr
  wr_idx     in   4   LED index 0..11
  wr_colour  in   2   00 off, 01 colour A, 10 colour B, 11 blend
  wr_mode    in   2   00 steady, 01 slow blink, 10 fast blink, 11 one-shot
  wr_err     out  1   one-cycle pulse: accepted write had wr_idx > 11
  led_yr     out  12  colour-A request to LED multiplexer
  led_bg     out  12  colour-B request to LED multiplexer

Function
REQ-005 A write SHALL be accepted on a rising edge where wr_valid & wr_ready; the entry {colour, mode} for wr_idx SHALL update on that edge.
REQ-006 Outputs SHALL be registered; an accepted write SHALL be visible on led_yr/led_bg at the next edge (1-cycle latency).
REQ-007 A write with wr_idx 12..15 SHALL be accepted, SHALL change no entry, and SHALL pulse wr_err high for the following cycle.
REQ-008 A prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick when it wraps.
REQ-009 A free-running 10-bit phase counter SHALL increment on each tick and wrap 1023->0.
REQ-010 Per LED i, "lit" SHALL be: steady = 1; slow blink = phase[9]==0; fast blink = phase[7]==0; one-shot = pulse timer nonzero.
REQ-011 led_yr[i] SHALL be lit & colour[0]; led_bg[i] SHALL be lit & colour[1].
REQ-012 A one-shot write SHALL load the LED's 8-bit timer with PULSE_TICKS; each tick SHALL decrement a nonzero timer.
REQ-013 When a timer decrements to 0, the entry SHALL return to {off, steady} on that edge.
REQ-014 A re-write of a one-shot LED SHALL reload its timer (retrigger).
REQ-015 A write of a non-one-shot mode SHALL clear that LED's timer.
REQ-016 If a write and timer expiry hit the same LED on the same edge, the write SHALL win.
REQ-017 clr SHALL set all entries to {off, steady} and all timers to 0 on the edge it is sampled high; any concurrent write SHALL be refused (wr_ready=0).
REQ-018 clr SHALL NOT reset the prescaler or phase counter.

Reset
REQ-019 On rst_n low, asynchronously: all entries {off, steady}, timers 0, prescaler 0, phase 0, led_yr=0, led_bg=0, wr_err=0.
REQ-020 wr_ready SHALL be 0 while rst_n is low.
REQ-021 Release of rst_n mid-write SHALL lose the write; no partial entry update SHALL occur.

Structure
REQ-022 Shared package led_pkg SHALL hold NUM_LEDS=12 and the colour and mode encodings; the LED multiplexer and this block SHALL both use it.
REQ-023 The prescaler plus phase counter SHALL be one sub-module, led_tick_gen, with outputs tick and phase[9:0].
REQ-024 Target size SHALL be 120-400 RTL lines; no memories, flops only.

Verification (bench uses TICK_DIV=4, PULSE_TICKS=3)
REQ-025 Write idx 5, colour 11, steady -> the next edge gives led_yr=led_bg=12'h020; all other bits stay 0.
REQ-026 Write idx 0, colour 01, slow blink -> led_yr[0] is high for phase 0..511 and low for 512..1023; it is high again after the wrap.
REQ-027 Write idx 11, colour 10, one-shot -> led_bg[11] is high for exactly 3 ticks (12 clks ±tick alignment), then low. A re-write at tick 2 extends it to tick 5.
REQ-028 Write idx 13 -> wr_err pulses high for 1 cycle; led_yr and led_bg are unchanged.
REQ-029 Set all LEDs steady, then assert clr with a concurrent write to idx 3 -> wr_ready=0 and all outputs are 0 on the next edge; the phase counter keeps its value.
REQ-030 Assert rst_n low asynchronously mid-blink -> outputs go to 0 without a clock edge. After release, phase restarts from 0.

Source files
------------

// File: rtl/led_pkg.sv
// Shared LED definitions: LED count, colour/mode encodings and the per-LED entry.
// Used by led_pattern_gen and by the downstream LED multiplexer.
package led_pkg;

    localparam int NUM_LEDS = 12;
    localparam int IDX_W    = 4;
    localparam int PHASE_W  = 10;
    localparam int TIMER_W  = 8;

    typedef enum logic [1:0] {
        COL_OFF   = 2'b00,
        COL_A     = 2'b01,
        COL_B     = 2'b10,
        COL_BLEND = 2'b11
    } colour_e;

    typedef enum logic [1:0] {
        MODE_STEADY  = 2'b00,
        MODE_SLOW    = 2'b01,
        MODE_FAST    = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    typedef struct packed {
        colour_e colour;
        mode_e   mode;
    } led_entry_t;

    localparam led_entry_t ENTRY_IDLE = '{colour: COL_OFF, mode: MODE_STEADY};

    // Whether an LED is lit this cycle, independent of its colour.
    function automatic logic led_lit(input mode_e mode,
                                     input logic [PHASE_W-1:0] phase,
                                     input logic pulse_active);
        logic lit;
        case (mode)
            MODE_STEADY:  lit = 1'b1;
            MODE_SLOW:    lit = ~phase[9];
            MODE_FAST:    lit = ~phase[7];
            MODE_ONESHOT: lit = pulse_active;
            default:      lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks, plus a free-running
// 10-bit phase counter advanced by each tick.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV = 12000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               tick,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic [15:0]        presc_q, presc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        phase_d = tick ? phase_q + 10'd1 : phase_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= 16'd0;
            phase_q <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Per-LED colour/mode table with blink and one-shot timing; drives registered
// colour-A and colour-B requests to the LED multiplexer.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int TICK_DIV    = 12000,
    parameter int PULSE_TICKS = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [1:0]          wr_colour,
    input  logic [1:0]          wr_mode,
    output logic                wr_err,
    output logic [NUM_LEDS-1:0] led_yr,
    output logic [NUM_LEDS-1:0] led_bg
);

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_TICKS);

    led_entry_t [NUM_LEDS-1:0]              entry_q, entry_d;
    logic       [NUM_LEDS-1:0][TIMER_W-1:0] timer_q, timer_d;
    logic       [NUM_LEDS-1:0]              led_yr_q, led_yr_d;
    logic       [NUM_LEDS-1:0]              led_bg_q, led_bg_d;
    logic                                   wr_err_q, wr_err_d;

    logic               tick;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic               wr_fire;
    logic               wr_in_range;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .phase (phase)
    );

    // Handshake: a write transfers on a rising edge where wr_valid and wr_ready
    // are both high; wr_ready is combinational and drops during reset and clr.
    assign wr_ready    = rst_n & ~clr;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = (wr_idx < IDX_W'(NUM_LEDS));

    always_comb begin
        entry_d   = entry_q;
        timer_d   = timer_q;
        led_yr_d  = '0;
        led_bg_d  = '0;
        wr_err_d  = wr_fire & ~wr_in_range;
        phase_nxt = tick ? phase + 10'd1 : phase;

        for (int i = 0; i < NUM_LEDS; i++) begin
            if (tick && (timer_q[i] != '0)) begin
                timer_d[i] = timer_q[i] - 8'd1;
                if (timer_q[i] == 8'd1) begin
                    entry_d[i] = ENTRY_IDLE;
                end
            end
            // Clear and writes are applied after expiry so they take priority.
            if (clr) begin
                entry_d[i] = ENTRY_IDLE;
                timer_d[i] = '0;
            end else if (wr_fire && (wr_idx == IDX_W'(i))) begin
                entry_d[i].colour = colour_e'(wr_colour);
                entry_d[i].mode   = mode_e'(wr_mode);
                timer_d[i]        = (mode_e'(wr_mode) == MODE_ONESHOT) ? PULSE_LOAD : '0;
            end
        end

        // Outputs are built from next-state so a write shows up right after its edge.
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_yr_d[i] = led_lit(entry_d[i].mode, phase_nxt, timer_d[i] != '0)
                          & entry_d[i].colour[0];
            led_bg_d[i] = led_lit(entry_d[i].mode, phase_nxt, timer_d[i] != '0)
                          & entry_d[i].colour[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q  <= {NUM_LEDS{ENTRY_IDLE}};
            timer_q  <= '0;
            led_yr_q <= '0;
            led_bg_q <= '0;
            wr_err_q <= 1'b0;
        end else begin
            entry_q  <= entry_d;
            timer_q  <= timer_d;
            led_yr_q <= led_yr_d;
            led_bg_q <= led_bg_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign led_yr = led_yr_q;
    assign led_bg = led_bg_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with TICK_DIV=4, PULSE_TICKS=3; expected
// blink/one-shot timing comes from a cycle counter kept since reset release.
module tb_led_pattern_gen;

    localparam int TDIV  = 4;
    localparam int PULSE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [3:0]  wr_idx = '0;
    logic [1:0]  wr_colour = '0;
    logic [1:0]  wr_mode = '0;
    logic        wr_err;
    logic [11:0] led_yr;
    logic [11:0] led_bg;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    led_pattern_gen #(
        .TICK_DIV    (TDIV),
        .PULSE_TICKS (PULSE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_idx    (wr_idx),
        .wr_colour (wr_colour),
        .wr_mode   (wr_mode),
        .wr_err    (wr_err),
        .led_yr    (led_yr),
        .led_bg    (led_bg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Edges since reset release; after edge k (sampled at negedge) cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model helpers ----------------
    function automatic int mphase();
        return (cyc / TDIV) % 1024;
    endfunction

    function automatic int tick_after(input int k, input int n);
        return TDIV * (k / TDIV + n);
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers (call at a negedge) ----------------
    task automatic wr(input int idx, input int col, input int mode);
        wr_valid  = 1'b1;
        wr_idx    = 4'(idx);
        wr_colour = 2'(col);
        wr_mode   = 2'(mode);
        @(negedge clk);
        wr_valid  = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
    endtask

    task automatic count_high11(output int n);
        n = 0;
        while (led_bg[11] && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kw, kr, n, errs, prev_ph, ph;
        logic saw_low, wrapped, hi_after_wrap, found;

        repeat (3) @(negedge clk);
        check("rst_yr", led_yr, 12'h000);
        check("rst_bg", led_bg, 12'h000);
        check("rst_err", wr_err, 1'b0);
        check("rst_ready", wr_ready, 1'b0);
        rst_n = 1'b1;
        #1 check("ready_after_rst", wr_ready, 1'b1);
        @(negedge clk);

        // Blend steady on LED 5
        wr(5, 3, 0);
        check("blend5_yr", led_yr, 12'h020);
        check("blend5_bg", led_bg, 12'h020);

        // Out-of-range index
        wr(13, 1, 0);
        check("err13_pulse", wr_err, 1'b1);
        check("err13_yr", led_yr, 12'h020);
        check("err13_bg", led_bg, 12'h020);
        @(negedge clk);
        check("err13_drop", wr_err, 1'b0);

        // Single colours and turning an LED off
        wr(2, 1, 0);
        check("a2_yr", led_yr, 12'h024);
        check("a2_bg", led_bg, 12'h020);
        check("a2_noerr", wr_err, 1'b0);
        wr(7, 2, 0);
        check("b7_yr", led_yr, 12'h024);
        check("b7_bg", led_bg, 12'h0A0);
        wr(5, 0, 0);
        check("off5_yr", led_yr, 12'h004);
        check("off5_bg", led_bg, 12'h080);

        // All steady blend, then clr with a concurrent write
        for (int i = 0; i < 12; i++) wr(i, 3, 0);
        check("all_yr", led_yr, 12'hFFF);
        check("all_bg", led_bg, 12'hFFF);
        found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin
            if (mphase() % 256 == 150) found = 1'b1;
            else @(negedge clk);
        end
        check("clr_phase_wait", found, 1'b1);
        clr = 1'b1;
        wr_valid = 1'b1; wr_idx = 4'd3; wr_colour = 2'd1; wr_mode = 2'd0;
        #1 check("clr_ready", wr_ready, 1'b0);
        @(negedge clk);
        clr = 1'b0; wr_valid = 1'b0;
        check("clr_yr", led_yr, 12'h000);
        check("clr_bg", led_bg, 12'h000);
        // Phase must have survived clr: at phase ~150, phase[7]=1 so fast blink is dark.
        wr(1, 1, 2);
        check("clr_keeps_phase", led_yr, ((mphase() >> 7) & 1) == 0 ? 12'h002 : 12'h000);
        check("clr_keeps_phase_bg", led_bg, 12'h000);

        // Slow blink sweep over a full phase period and past the wrap
        clr_pulse();
        wr(0, 1, 1);
        errs = 0; saw_low = 1'b0; wrapped = 1'b0; hi_after_wrap = 1'b0;
        prev_ph = mphase();
        for (int i = 0; i < 4400; i++) begin
            ph = mphase();
            if (ph < prev_ph) wrapped = 1'b1;
            prev_ph = ph;
            if (led_yr[0] !== ((ph < 512) ? 1'b1 : 1'b0)) errs++;
            if (led_yr[11:1] !== 11'd0 || led_bg !== 12'd0) errs++;
            if (led_yr[0] === 1'b0) saw_low = 1'b1;
            if (wrapped && led_yr[0] === 1'b1) hi_after_wrap = 1'b1;
            @(negedge clk);
        end
        check("slow_sweep_errs", errs, 0);
        check("slow_saw_low", saw_low, 1'b1);
        check("slow_high_after_wrap", hi_after_wrap, 1'b1);

        // One-shot on LED 11, colour B
        clr_pulse();
        wr(11, 2, 3);
        kw = cyc;
        check("os_bg_on", led_bg, 12'h800);
        check("os_yr", led_yr, 12'h000);
        count_high11(n);
        check("os_len", n, tick_after(kw, 3) - kw);
        check("os_off_bg", led_bg, 12'h000);

        // Retrigger after the second tick
        wr(11, 2, 3);
        kw = cyc;
        wait_cyc(tick_after(kw, 2));
        check("rt_still_on", led_bg[11], 1'b1);
        wr(11, 2, 3);
        kr = cyc;
        count_high11(n);
        check("rt_len", n, tick_after(kr, 3) - kr);
        check("rt_total", kr + n - kw, tick_after(kw, 5) - kw);

        // Write lands on the same edge the timer expires: write wins
        wr(11, 2, 3);
        kw = cyc;
        wait_cyc(tick_after(kw, 3) - 1);
        wr(11, 1, 3);
        check("same_edge_cyc", cyc, tick_after(kw, 3));
        check("same_edge_yr", led_yr, 12'h800);
        check("same_edge_bg", led_bg, 12'h000);
        clr_pulse();

        // Asynchronous reset in the middle of blinking
        wr(4, 3, 0);
        wr(0, 1, 2);
        check("pre_rst_yr4", led_yr[4], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_yr", led_yr, 12'h000);
        check("async_rst_bg", led_bg, 12'h000);
        check("async_rst_ready", wr_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_yr", led_yr, 12'h000);
        wr(0, 1, 2);
        wait_cyc(TDIV * 128 - 1);
        check("post_rst_ph127", led_yr, 12'h001);
        @(negedge clk);
        check("post_rst_ph128", led_yr, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
